// File: rtl/bus_pkg.sv
// Shared bus definitions: source enable count, select width, source index map and arbiter state.
package bus_pkg;

  localparam int unsigned NUM_SRC = 24;
  localparam int unsigned SEL_W   = 5;

  localparam logic [SEL_W-1:0] SRC_R0     = 5'd0;
  localparam logic [SEL_W-1:0] SRC_R1     = 5'd1;
  localparam logic [SEL_W-1:0] SRC_R2     = 5'd2;
  localparam logic [SEL_W-1:0] SRC_R3     = 5'd3;
  localparam logic [SEL_W-1:0] SRC_R4     = 5'd4;
  localparam logic [SEL_W-1:0] SRC_R5     = 5'd5;
  localparam logic [SEL_W-1:0] SRC_R6     = 5'd6;
  localparam logic [SEL_W-1:0] SRC_R7     = 5'd7;
  localparam logic [SEL_W-1:0] SRC_R8     = 5'd8;
  localparam logic [SEL_W-1:0] SRC_R9     = 5'd9;
  localparam logic [SEL_W-1:0] SRC_R10    = 5'd10;
  localparam logic [SEL_W-1:0] SRC_R11    = 5'd11;
  localparam logic [SEL_W-1:0] SRC_R12    = 5'd12;
  localparam logic [SEL_W-1:0] SRC_R13    = 5'd13;
  localparam logic [SEL_W-1:0] SRC_R14    = 5'd14;
  localparam logic [SEL_W-1:0] SRC_R15    = 5'd15;
  localparam logic [SEL_W-1:0] SRC_MDR    = 5'd16;
  localparam logic [SEL_W-1:0] SRC_HI     = 5'd17;
  localparam logic [SEL_W-1:0] SRC_LO     = 5'd18;
  localparam logic [SEL_W-1:0] SRC_ZHIGH  = 5'd19;
  localparam logic [SEL_W-1:0] SRC_ZLOW   = 5'd20;
  localparam logic [SEL_W-1:0] SRC_PC     = 5'd21;
  localparam logic [SEL_W-1:0] SRC_INPORT = 5'd22;
  localparam logic [SEL_W-1:0] SRC_C      = 5'd23;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/bus_source_arbiter_if.sv
// Requester-side handshake and source enable bundle of the bus source arbiter.
interface bus_source_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned NUM_SRC = 24
);

  logic [NUM_REQ-1:0]                req;
  logic [NUM_REQ*bus_pkg::SEL_W-1:0] src_sel;
  logic [NUM_REQ-1:0]                last;
  logic [NUM_REQ-1:0]                gnt;
  logic [NUM_SRC-1:0]                src_en;
  logic                              busy;
  logic                              timeout;

  modport master (
    output req, src_sel, last,
    input  gnt, src_en, busy, timeout
  );

  modport slave (
    input  req, src_sel, last,
    output gnt, src_en, busy, timeout
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after start, wrapping.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     win_c,
  output logic [IDX_W-1:0] win_idx_c,
  output logic             win_vld_c
);

  // Scan N positions from start; the first hit wins.
  always_comb begin
    int unsigned j;
    win_c     = '0;
    win_idx_c = '0;
    win_vld_c = 1'b0;
    j         = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = int'(start) + k;
      if (j >= N) j = j - N;
      if (!win_vld_c && req[j]) begin
        win_vld_c = 1'b1;
        win_c[j]  = 1'b1;
        win_idx_c = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/bus_source_arbiter.sv
// Bus source arbiter: round-robin tenure grant plus one-hot source enable decode.
// Optional macro BUS_ARB_TIMEOUT_EN adds a tenure limit of TIMEOUT cycles.
module bus_source_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned NUM_SRC = 24,
  parameter int unsigned TIMEOUT = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  bus_source_arbiter_if.slave bus
);

  import bus_pkg::*;

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (TIMEOUT == 0) begin : g_timeout_chk
    $error("TIMEOUT must be at least 1");
  end

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               busy_q;

  logic [NUM_REQ-1:0] win_c;
  logic [IDX_W-1:0]   win_idx_c;
  logic               win_vld_c;
  logic               rel_c;
  logic [SEL_W-1:0]   sel_c;
  logic [NUM_SRC-1:0] src_en_c;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req       (bus.req),
    .start     (ptr_q),
    .win_c     (win_c),
    .win_idx_c (win_idx_c),
    .win_vld_c (win_vld_c)
  );

  assign rel_c = bus.last[owner_q] | ~bus.req[owner_q];

  // State register: FSM, grant, owner, round-robin pointer and tenure counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      busy_q    <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      busy_q    <= |gnt_d;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  // Next state: grant from IDLE, release (or forced release) from OWNED.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
`ifdef BUS_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (win_vld_c) begin
          state_d = ST_OWNED;
          gnt_d   = win_c;
          owner_d = win_idx_c;
          ptr_d   = (win_idx_c == IDX_W'(NUM_REQ - 1)) ? '0 : IDX_W'(win_idx_c + 1'b1);
`ifdef BUS_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_OWNED: begin
        if (rel_c) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = ST_IDLE;
          gnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Output decode: owner's current source select to a one-hot enable; out-of-map gives zero.
  always_comb begin
    src_en_c = '0;
    sel_c    = bus.src_sel[int'(owner_q)*SEL_W +: SEL_W];
    if (state_q == ST_OWNED && int'(sel_c) < int'(NUM_SRC)) begin
      src_en_c = NUM_SRC'(1) << sel_c;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.src_en = src_en_c;
  assign bus.busy   = busy_q;
`ifdef BUS_ARB_TIMEOUT_EN
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Directed bench for bus_source_arbiter with an expectation queue checked at each negedge.
module tb_bus_source_arbiter;

  import bus_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned NS = 24;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst_n;

  bus_source_arbiter_if #(.NUM_REQ(NR), .NUM_SRC(NS)) bus ();

  bus_source_arbiter #(
    .NUM_REQ (NR),
    .NUM_SRC (NS),
    .TIMEOUT (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0] gnt;
    logic [NS-1:0] src_en;
    logic          busy;
    logic          to;
    string         tag;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [NS-1:0] oh(int b);
    logic [NS-1:0] v;
    v = '0;
    if (b >= 0 && b < int'(NS)) v[b] = 1'b1;
    return v;
  endfunction

  task automatic expect_out(logic [NR-1:0] g, int src, logic to, string tag);
    exp_t e;
    e.gnt    = g;
    e.src_en = oh(src);
    e.busy   = |g;
    e.to     = to;
    e.tag    = tag;
    sb.push_back(e);
  endtask

  task automatic cmp_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL scoreboard_empty got 0 entries want 1");
      return;
    end
    e = sb.pop_front();
    n_tests++;
    assert (bus.gnt === e.gnt) else begin
      n_fail++;
      $error("FAIL %s gnt got %b want %b", e.tag, bus.gnt, e.gnt);
    end
    n_tests++;
    assert (bus.src_en === e.src_en) else begin
      n_fail++;
      $error("FAIL %s src_en got %h want %h", e.tag, bus.src_en, e.src_en);
    end
    n_tests++;
    assert (bus.busy === e.busy) else begin
      n_fail++;
      $error("FAIL %s busy got %b want %b", e.tag, bus.busy, e.busy);
    end
    n_tests++;
    assert (bus.timeout === e.to) else begin
      n_fail++;
      $error("FAIL %s timeout got %b want %b", e.tag, bus.timeout, e.to);
    end
  endtask

  task automatic step(logic [NR-1:0] g, int src, logic to, string tag);
    expect_out(g, src, to, tag);
    @(negedge clk);
    cmp_out();
  endtask

  task automatic set_sel(int i, int v);
    bus.src_sel[i*SEL_W +: SEL_W] = SEL_W'(v);
  endtask

  task automatic pulse_reset();
    bus.req  = '0;
    bus.last = '0;
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    bus.req     = '0;
    bus.src_sel = '0;
    bus.last    = '0;
    repeat (2) @(negedge clk);
    expect_out('0, -1, 1'b0, "reset");
    cmp_out();
    rst_n = 1'b1;

    // Single grant with PC as source, then release by dropping req
    bus.req = 4'b0001;
    set_sel(0, int'(SRC_PC));
    step(4'b0001, int'(SRC_PC), 1'b0, "pc_grant");
    bus.req = '0;
    step('0, -1, 1'b0, "pc_release");

    // Round-robin with all requesting, one idle cycle between tenures
    pulse_reset();
    for (int i = 0; i < int'(NR); i++) set_sel(i, i);
    bus.req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      int k;
      k = n % int'(NR);
      step(NR'(1 << k), k, 1'b0, $sformatf("rr_grant%0d", n));
      bus.last = NR'(1 << k);
      step('0, -1, 1'b0, $sformatf("rr_idle%0d", n));
      bus.last = '0;
    end
    bus.req = '0;
    step('0, -1, 1'b0, "rr_done");

    // Owner 2 changes source every cycle, including an out-of-map index
    pulse_reset();
    bus.req = 4'b0100;
    set_sel(2, int'(SRC_MDR));
    step(4'b0100, int'(SRC_MDR), 1'b0, "sel_mdr");
    set_sel(2, int'(SRC_ZLOW));
    step(4'b0100, int'(SRC_ZLOW), 1'b0, "sel_zlow");
    set_sel(2, 25);
    step(4'b0100, -1, 1'b0, "sel_invalid");

    // Non-owner last and req activity does not disturb the tenure
    bus.last = 4'b1011;
    bus.req  = 4'b1111;
    step(4'b0100, -1, 1'b0, "nonowner_a");
    set_sel(2, int'(SRC_C));
    bus.req  = 4'b0101;
    bus.last = 4'b1001;
    step(4'b0100, int'(SRC_C), 1'b0, "nonowner_b");
    bus.req  = 4'b1110;
    bus.last = 4'b0011;
    step(4'b0100, int'(SRC_C), 1'b0, "nonowner_c");
    bus.last = '0;
    bus.req  = '0;
    step('0, -1, 1'b0, "nonowner_release");

    // Asynchronous reset mid-tenure, then pointer restarts at requester 0
    bus.req = 4'b0010;
    set_sel(1, int'(SRC_HI));
    step(4'b0010, int'(SRC_HI), 1'b0, "pre_reset_grant");
    #2 rst_n = 1'b0;
    #1;
    expect_out('0, -1, 1'b0, "async_reset");
    cmp_out();
    #1 rst_n = 1'b1;
    bus.req = 4'b1010;
    set_sel(3, int'(SRC_INPORT));
    step(4'b0010, int'(SRC_HI), 1'b0, "ptr_after_reset");
    bus.req = '0;
    step('0, -1, 1'b0, "ptr_release");
    bus.req = 4'b1000;
    step(4'b1000, int'(SRC_INPORT), 1'b0, "req3_grant");
    bus.req = '0;
    step('0, -1, 1'b0, "req3_release");

    // Tenure limit behaviour
    pulse_reset();
    set_sel(0, int'(SRC_R5));
    bus.req = 4'b0001;
`ifdef BUS_ARB_TIMEOUT_EN
    for (int n = 0; n < int'(TO); n++) begin
      step(4'b0001, int'(SRC_R5), 1'b0, $sformatf("to_hold%0d", n));
    end
    step('0, -1, 1'b1, "to_forced");
    step(4'b0001, int'(SRC_R5), 1'b0, "to_regrant");
`else
    for (int n = 0; n < 40; n++) begin
      step(4'b0001, int'(SRC_R5), 1'b0, $sformatf("unbounded%0d", n));
    end
`endif
    bus.req = '0;
    step('0, -1, 1'b0, "to_release");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_source_arbiter.md
BUS_SOURCE_ARBITER -- requirements
Module: bus_source_arbiter

Interface
REQ-001 Parameter NUM_REQ, 4, number of requesters competing for the shared 32-bit bus.
REQ-002 Parameter NUM_SRC, 24, number of bus source enables driven.
REQ-003 Parameter TIMEOUT, 16, maximum tenure in cycles; used only when the timeout feature is compiled in.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 req  in  NUM_REQ  per-requester bus request, level.
REQ-007 src_sel  in  NUM_REQ*5  per-requester 5-bit source index, requester i at bits [5i+4:5i].
REQ-008 last  in  NUM_REQ  per-requester release; meaningful only while that requester holds gnt.
REQ-009 gnt  out  NUM_REQ  registered one-hot grant; all-zero when idle.
REQ-010 src_en  out  NUM_SRC  one-hot bus source enables.
REQ-011 busy  out  1  high while any gnt bit is set.
REQ-012 timeout  out  1  one-cycle pulse on a forced release.

Function
REQ-013 Source index map: 0-15 R0-R15; 16 MDR; 17 HI; 18 LO; 19 Zhigh; 20 Zlow; 21 PC; 22 InPort; 23 C.
REQ-014 FSM states: IDLE and OWNED.
REQ-015 IDLE: gnt=0, src_en=0; if any req bit is set at an edge, the round-robin winner's gnt bit is set at that edge and the FSM enters OWNED (latency: req seen at cycle N gives gnt in cycle N+1).
REQ-016 Round-robin: search starts at (last_owner+1) mod NUM_REQ and wraps; pointer updates only on grant.
REQ-017 OWNED: src_en = one-hot decode of the owner's current src_sel, combinational, so the owner may change source every cycle.
REQ-018 An src_sel value of 24-31 gives src_en=0; src_en is never multi-hot.
REQ-019 Release: the owner's last=1 or req=0 at an edge clears gnt at that edge and returns the FSM to IDLE.
REQ-020 At least one IDLE turnaround cycle separates consecutive tenures, including back-to-back grants to the same requester.
REQ-021 req or last from non-owners during OWNED is ignored; last outside a tenure is ignored.
REQ-022 A request arriving in the same cycle as a release is arbitrated on the next edge from IDLE.

Reset
REQ-023 rst_n low forces gnt=0, src_en=0, busy=0, timeout=0, FSM=IDLE, tenure counter=0, and round-robin pointer such that requester 0 has highest priority, all immediately and without waiting for clk.
REQ-024 Reset asserted mid-tenure drops the grant with no release handshake; the first arbitration after deassertion occurs at the first clk edge with rst_n high.

Configuration
REQ-025 Macro BUS_ARB_TIMEOUT_EN defined: a tenure counter runs in OWNED; when a tenure reaches TIMEOUT cycles without release, gnt is cleared, the FSM enters IDLE, and timeout pulses high for one cycle.
REQ-026 Macro BUS_ARB_TIMEOUT_EN undefined: no counter is built, the timeout port remains present and is tied 0, and tenure is unbounded.

Structure
REQ-027 Shared package bus_pkg holds: NUM_SRC, SEL_W=5, and named source index constants SRC_R0..SRC_R15, SRC_MDR, SRC_HI, SRC_LO, SRC_ZHIGH, SRC_ZLOW, SRC_PC, SRC_INPORT, SRC_C.
REQ-028 One sub-module, rr_arbiter, is combinational and takes request and pointer inputs and produces a one-hot winner; FSM, decode and counter reside in bus_source_arbiter.

Verification
REQ-029 Reset then req=0001, src_sel0=21 -> gnt=0001 next cycle, src_en bit 21 (PC) only, busy=1.
REQ-030 req=1111 held, each owner asserts last one cycle after grant -> grant order 0001, 0010, 0100, 1000, 0001, with one idle cycle between tenures.
REQ-031 Owner 2 holds, src_sel2 steps 16, 20, 25 -> src_en bit 16, then bit 20, then all-zero; never multi-hot.
REQ-032 rst_n pulsed low mid-tenure between clk edges -> gnt and src_en zero immediately; after release, req=1000 with pointer reset gives gnt=1000.
REQ-033 BUS_ARB_TIMEOUT_EN defined, TIMEOUT=16, owner never asserts last -> gnt cleared after 16 granted cycles, timeout high for exactly 1 cycle; without the macro, gnt is still held at 40 cycles and timeout stays 0.
REQ-034 Non-owner last=1 and req toggles during a tenure -> gnt unchanged.
